// File: rtl/shift_pkg.sv
// Shared types and constants for the sequencing shift register.
package shift_pkg;

    typedef enum logic [1:0] {
        LOGIC  = 2'b00,
        ARITH  = 2'b01,
        ROTATE = 2'b10,
        RSVD   = 2'b11
    } shift_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } seq_state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shift_step.sv
// One-position shift of a WIDTH-bit word; shared by the single-step and sequenced paths.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_data,
    input  shift_mode_t      i_mode,
    input  logic             i_dir,
    input  logic             i_shift_in,
    output logic [WIDTH-1:0] o_next_c
);

    logic w_fill;

    // Pick the bit entering the vacated end, then splice it in.
    always_comb begin
        w_fill = i_shift_in;
        case (i_mode)
            ARITH:   w_fill = (i_dir == DIR_LEFT) ? 1'b0 : i_data[WIDTH-1];
            ROTATE:  w_fill = (i_dir == DIR_LEFT) ? i_data[WIDTH-1] : i_data[0];
            default: w_fill = i_shift_in;
        endcase

        if (i_dir == DIR_LEFT) begin
            o_next_c = {i_data[WIDTH-2:0], w_fill};
        end else begin
            o_next_c = {w_fill, i_data[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/shift_reg_seq.sv
// Parametrised load/shift register with a multi-bit shift sequencer
// (Start/Busy/Done handshake); single-step shifts are available in IDLE.
module shift_reg_seq
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    input  logic             Shift_En,
    input  logic             Start,
    input  logic [CW-1:0]    Count,
    input  shift_mode_t      Mode,
    input  logic             Dir,
    input  logic             Shift_In,
    output logic             Shift_Out,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Data_Out
);

    localparam logic [CW-1:0] MAX_CNT = CW'(WIDTH);

    seq_state_t       r_state;
    logic [CW-1:0]    r_rem;
    shift_mode_t      r_mode;
    logic             r_dir;
    logic [WIDTH-1:0] r_data;
    logic             r_busy;
    logic             r_done;

    seq_state_t       w_state_nxt;
    logic [CW-1:0]    w_rem_nxt;
    shift_mode_t      w_mode_nxt;
    logic             w_dir_nxt;
    logic [WIDTH-1:0] w_data_nxt;
    logic [CW-1:0]    w_cnt_clamp;
    shift_mode_t      w_step_mode;
    logic             w_step_dir;
    logic [WIDTH-1:0] w_step;

    assign w_cnt_clamp = (Count > MAX_CNT) ? MAX_CNT : Count;

    // Live controls drive single steps in IDLE; latched ones drive the sequence.
    assign w_step_mode = (r_state == IDLE) ? Mode : r_mode;
    assign w_step_dir  = (r_state == IDLE) ? Dir  : r_dir;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_data     (r_data),
        .i_mode     (w_step_mode),
        .i_dir      (w_step_dir),
        .i_shift_in (Shift_In),
        .o_next_c   (w_step)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_rem   <= '0;
            r_mode  <= LOGIC;
            r_dir   <= DIR_RIGHT;
            r_data  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_mode  <= w_mode_nxt;
            r_dir   <= w_dir_nxt;
            r_data  <= w_data_nxt;
            r_busy  <= (w_state_nxt == SHIFT);
            r_done  <= (w_state_nxt == DONE);
        end
    end

    // Next-state and datapath mux; Load beats every other command in every state.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_mode_nxt  = r_mode;
        w_dir_nxt   = r_dir;
        w_data_nxt  = r_data;

        case (r_state)
            IDLE: begin
                if (Load) begin
                    w_data_nxt = D;
                end else if (Start) begin
                    if (w_cnt_clamp == '0) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = SHIFT;
                        w_rem_nxt   = w_cnt_clamp;
                        w_mode_nxt  = Mode;
                        w_dir_nxt   = Dir;
                    end
                end else if (Shift_En) begin
                    w_data_nxt = w_step;
                end
            end
            SHIFT: begin
                if (Load) begin
                    w_data_nxt  = D;
                    w_rem_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_data_nxt = w_step;
                    w_rem_nxt  = r_rem - CW'(1);
                    if (r_rem == CW'(1)) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                if (Load) begin
                    w_data_nxt = D;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign Shift_Out = (w_step_dir == DIR_LEFT) ? r_data[WIDTH-1] : r_data[0];
    assign Busy      = r_busy;
    assign Done      = r_done;
    assign Data_Out  = r_data;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Self-checking bench for shift_reg_seq (WIDTH = 8) using an expected-result queue.
module tb_shift_reg_seq;
    import shift_pkg::*;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CW    = $clog2(WIDTH + 1);

    logic             Clk = 1'b0;
    logic             Reset_n = 1'b0;
    logic             Load = 1'b0;
    logic [WIDTH-1:0] D = '0;
    logic             Shift_En = 1'b0;
    logic             Start = 1'b0;
    logic [CW-1:0]    Count = '0;
    shift_mode_t      Mode = LOGIC;
    logic             Dir = 1'b0;
    logic             Shift_In = 1'b0;
    logic             Shift_Out;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Data_Out;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] sb_q[$];

    shift_reg_seq #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Load      (Load),
        .D         (D),
        .Shift_En  (Shift_En),
        .Start     (Start),
        .Count     (Count),
        .Mode      (Mode),
        .Dir       (Dir),
        .Shift_In  (Shift_In),
        .Shift_Out (Shift_Out),
        .Busy      (Busy),
        .Done      (Done),
        .Data_Out  (Data_Out)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bit-level reference for n steps of one mode/direction.
    function automatic logic [7:0] model_seq(input logic [7:0] v, input int n, input shift_mode_t m,
                                             input logic dr, input logic sin);
        logic [7:0] x;
        logic       fill;
        x = v;
        for (int k = 0; k < n; k++) begin
            if (dr) begin
                fill = (m == ARITH) ? 1'b0 : (m == ROTATE) ? x[7] : sin;
                x    = {x[6:0], fill};
            end else begin
                fill = (m == ARITH) ? x[7] : (m == ROTATE) ? x[0] : sin;
                x    = {fill, x[7:1]};
            end
        end
        return x;
    endfunction

    task automatic load_val(input logic [7:0] v);
        @(negedge Clk);
        Load = 1'b1;
        D    = v;
        @(negedge Clk);
        Load = 1'b0;
        check_eq("load", 32'(Data_Out), 32'(v));
    endtask

    // Start a sequence, expect Busy for min(cnt,8) cycles then one Done pulse.
    task automatic run_seq(input string tag, input logic [7:0] init, input int cnt, input shift_mode_t m,
                           input logic dr, input logic sin, input logic [7:0] exp, input bit poke);
        int         n_eff;
        int         busy_cyc;
        int         both;
        int         guard;
        bit         seen;
        logic [7:0] want;
        n_eff = (cnt > 8) ? 8 : cnt;
        load_val(init);
        sb_q.push_back(exp);
        Count    = CW'(cnt);
        Mode     = m;
        Dir      = dr;
        Shift_In = sin;
        Start    = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        if (poke && n_eff > 0) begin
            // A second Start plus changed live controls must not disturb the sequence.
            Count = CW'(1);
            Mode  = ROTATE;
            Dir   = ~dr;
            Start = 1'b1;
        end
        seen     = 1'b0;
        busy_cyc = 0;
        both     = 0;
        guard    = 0;
        while (!seen && guard < 40) begin
            if (Busy && Done) both++;
            if (Done) begin
                seen = 1'b1;
            end else begin
                if (Busy) busy_cyc++;
                @(negedge Clk);
                Start = 1'b0;
                guard++;
            end
        end
        check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
        check_eq({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(n_eff));
        check_eq({tag, "_busy_and_done"}, 32'(both), 32'd0);
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            want = sb_q.pop_front();
            check_eq({tag, "_data"}, 32'(Data_Out), 32'(want));
        end
        Start = 1'b0;
        @(negedge Clk);
        check_eq({tag, "_done_pulse"}, 32'(Done), 32'd0);
        Mode = LOGIC;
        Dir  = DIR_RIGHT;
    endtask

    logic [7:0]  r_init;
    logic [7:0]  r_exp;
    int          r_cnt;
    shift_mode_t r_mode;
    logic        r_dir;
    logic        r_sin;
    int          r_done_cnt;

    initial begin
        // Reset values
        #12;
        check_eq("rst_data", 32'(Data_Out), 32'h0);
        check_eq("rst_busy", 32'(Busy), 32'd0);
        check_eq("rst_done", 32'(Done), 32'd0);
        check_eq("rst_sout", 32'(Shift_Out), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Load and Shift_Out in both directions
        load_val(8'hA5);
        check_eq("sout_right", 32'(Shift_Out), 32'd1);
        Dir = DIR_LEFT;
        #1;
        check_eq("sout_left", 32'(Shift_Out), 32'd1);
        Dir = DIR_RIGHT;
        load_val(8'h5E);
        check_eq("sout_right_0", 32'(Shift_Out), 32'd0);

        run_seq("logic_r3", 8'hA5, 3, LOGIC, DIR_RIGHT, 1'b0, 8'h14, 1'b1);
        run_seq("arith_r2", 8'h90, 2, ARITH, DIR_RIGHT, 1'b1, 8'hE4, 1'b0);
        run_seq("arith_l1", 8'h81, 1, ARITH, DIR_LEFT, 1'b1, 8'h02, 1'b0);
        run_seq("rot_l4", 8'h3C, 4, ROTATE, DIR_LEFT, 1'b0, 8'hC3, 1'b0);
        run_seq("rot_r8", 8'h5A, 8, ROTATE, DIR_RIGHT, 1'b0, 8'h5A, 1'b0);
        run_seq("rot_r15", 8'h5A, 15, ROTATE, DIR_RIGHT, 1'b0, 8'h5A, 1'b1);
        run_seq("rsvd_l2", 8'h81, 2, RSVD, DIR_LEFT, 1'b1, 8'h07, 1'b0);
        run_seq("cnt0", 8'h66, 0, LOGIC, DIR_RIGHT, 1'b1, 8'h66, 1'b0);

        // Load aborts a running sequence without Done
        load_val(8'hF0);
        Count = CW'(5);
        Mode  = LOGIC;
        Dir   = DIR_RIGHT;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        check_eq("abort_busy_on", 32'(Busy), 32'd1);
        @(negedge Clk);
        Load = 1'b1;
        D    = 8'h0F;
        @(negedge Clk);
        Load = 1'b0;
        check_eq("abort_data", 32'(Data_Out), 32'h0F);
        check_eq("abort_busy", 32'(Busy), 32'd0);
        check_eq("abort_done", 32'(Done), 32'd0);
        @(negedge Clk);
        check_eq("abort_done_later", 32'(Done), 32'd0);

        // Asynchronous reset mid-sequence
        load_val(8'hA5);
        Count = CW'(6);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        check_eq("async_data", 32'(Data_Out), 32'h0);
        check_eq("async_busy", 32'(Busy), 32'd0);
        check_eq("async_sout", 32'(Shift_Out), 32'd0);
        @(negedge Clk);
        Reset_n    = 1'b1;
        r_done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            if (Done) r_done_cnt++;
        end
        check_eq("async_no_done", 32'(r_done_cnt), 32'd0);

        // Single steps in IDLE with live controls
        load_val(8'h80);
        Mode     = LOGIC;
        Dir      = DIR_LEFT;
        Shift_In = 1'b1;
        Shift_En = 1'b1;
        @(negedge Clk);
        Shift_En = 1'b0;
        check_eq("step_logic_l", 32'(Data_Out), 32'h01);
        check_eq("step_busy", 32'(Busy), 32'd0);
        load_val(8'h81);
        Mode     = ROTATE;
        Dir      = DIR_RIGHT;
        Shift_En = 1'b1;
        @(negedge Clk);
        Shift_En = 1'b0;
        check_eq("step_rot_r", 32'(Data_Out), 32'hC0);
        Mode = LOGIC;

        // Randomised sequences against the reference model
        for (int i = 0; i < 6; i++) begin
            r_init = 8'($urandom);
            r_cnt  = int'($urandom_range(0, 15));
            r_mode = shift_mode_t'(2'($urandom_range(0, 3)));
            r_dir  = 1'($urandom);
            r_sin  = 1'($urandom);
            r_exp  = model_seq(r_init, (r_cnt > 8) ? 8 : r_cnt, r_mode, r_dir, r_sin);
            run_seq("rand", r_init, r_cnt, r_mode, r_dir, r_sin, r_exp, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/shift_reg_seq.md
# shift_reg_seq

Parametrised sequencing shift register, the next generation of the team's 8-bit load/shift registers. It adds the following over the fixed-width parts:
- generic width;
- left or right direction;
- logical, arithmetic and rotate modes;
- a multi-bit shift sequencer with a Start/Busy/Done handshake.

It sits in the datapath as the operand register for serial multiply/divide and the shift unit. In single-step mode it remains usable as a plain load/shift register.

## Interface
- WIDTH, 8: register width in bits; must be at least 2.
- CW, $clog2(WIDTH+1): width of Count.

- Clk  in  1  clock; all state changes on the rising edge.
- Reset_n  in  1  reset; asynchronous, active-low.
- Load  in  1  parallel load of D; highest-priority command.
- D  in  WIDTH  parallel load data.
- Shift_En  in  1  single one-bit shift, using Mode and Dir; honoured only in IDLE.
- Start  in  1  begin a multi-bit shift of Count positions; honoured only in IDLE.
- Count  in  CW  shift amount, latched on Start; values above WIDTH are clamped to WIDTH.
- Mode  in  2  shift_mode_t; latched on Start.
- Dir  in  1  0 = right, 1 = left; latched on Start.
- Shift_In  in  1  serial fill bit; sampled on every shift edge.
- Shift_Out  out  1  bit next to leave the register: Data_Out[0] when shifting right, Data_Out[WIDTH-1] when shifting left.
- Busy  out  1  high while the sequencer is in SHIFT.
- Done  out  1  one-cycle pulse when a sequence completes.
- Data_Out  out  WIDTH  register contents.

## Operation
Mode semantics for one step:
- LOGIC (2'b00):
  - right: {Shift_In, Data_Out[WIDTH-1:1]}.
  - left: {Data_Out[WIDTH-2:0], Shift_In}.
- ARITH (2'b01):
  - right: the MSB is replicated.
  - left: 0 is filled into the LSB.
  - Shift_In is ignored.
- ROTATE (2'b10): the bit leaving one end enters the other end. Shift_In is ignored.
- 2'b11: reserved; behaves as LOGIC.

States are IDLE, SHIFT and DONE.
- IDLE, with priority Load > Start > Shift_En:
  - Load: Data_Out <= D.
  - Start with clamped Count = 0: go to DONE; data unchanged.
  - Start with Count ≥ 1: latch Mode, Dir and Count into the remaining counter; go to SHIFT.
  - Shift_En: perform one step using the live Mode and Dir; stay in IDLE.
- SHIFT:
  - Each edge performs one step using the latched Mode and Dir, and decrements the remaining counter.
  - The edge on which remaining goes 1 -> 0 also moves the FSM to DONE.
  - Start and Shift_En are ignored.
  - Load aborts the sequence: Data_Out <= D, go to IDLE, Done is not asserted.
- DONE:
  - Done = 1 for exactly one cycle; next state is IDLE.
  - Load is honoured (loads D, goes to IDLE).
  - Start and Shift_En are ignored.
- Shift_Out uses the latched Dir in SHIFT and DONE, and the live Dir in IDLE.

## Timing
- Reset values (asynchronous, on Reset_n low): Data_Out = 0, state = IDLE, Busy = 0, Done = 0, remaining = 0. Shift_Out therefore reads 0.
- Reset asserted mid-sequence aborts immediately; no Done is produced.
- Load: Data_Out is valid one cycle after the Load edge.
- Start sampled at edge 0 with Count = N ≥ 1:
  - Busy is high from edge 0 to edge N.
  - Shifts occur at edges 1..N.
  - Done is high between edges N and N+1.
  - Data_Out is final after edge N.
  - The next Start is accepted at edge N+1 or later.
- Start with Count = 0: Done is high for the cycle after edge 0.
- Back-to-back Start while Busy or Done is high: ignored, not queued.
- Busy and Done are registered outputs and are never high together.

## Structure
- Package shift_pkg holds:
  - shift_mode_t enum: LOGIC, ARITH, ROTATE, RSVD;
  - seq_state_t enum: IDLE, SHIFT, DONE;
  - direction constants DIR_RIGHT = 0 and DIR_LEFT = 1.
- Sub-module shift_step, parametrised on WIDTH, is combinational. It computes the one-step next value from (Data_Out, Mode, Dir, Shift_In) and is shared by the single-step and sequenced paths.
- Top level contains:
  - the FSM;
  - the Count clamp and remaining counter;
  - the next-state mux;
  - the registers.

## Test plan
All scenarios use WIDTH = 8.
1. Reset_n low, then Load D=8'hA5 -> Data_Out = 8'hA5 one cycle later, Shift_Out = 1.
2. From 8'hA5, Start Count=3, LOGIC, right, Shift_In=0 -> Busy high for 3 cycles, then Done pulses once; Data_Out = 8'h14.
3. From 8'h90, Start Count=2, ARITH, right -> Data_Out = 8'hE4.
4. From 8'h3C, ROTATE left Count=4 -> 8'hC3. From 8'h5A, ROTATE right Count=8 -> 8'h5A, with Done after 8 shift cycles. From 8'h5A, Count=15 -> clamped to 8, same result.
5. Load D=8'h0F on the 2nd SHIFT cycle -> Data_Out = 8'h0F, Busy low next cycle, no Done. Separately, Start with Count=0 -> Done next cycle, data unchanged.
6. Reset_n low asynchronously mid-SHIFT -> Data_Out = 0 and Busy = 0 before the next edge. In IDLE, Shift_En with LOGIC left, Shift_In=1 on 8'h80 -> 8'h01.
